mxv_push_sequencer: RTL
=======================

Name: mxv_push_sequencer

Overview:
Control FSM for the matrix-vector (MxV) datapath. It accepts a start command and a runtime dimension. It streams the vector, then the matrix row-major, from an upstream valid/ready source into the per-row push counters and processing elements, using indexed push strobes. After a fixed pipeline drain it pops one result per row and signals done.

Parameters:
NBITS_FOR_COUNTER, 3, width of size/row/column indices; max dimension = 2**NBITS_FOR_COUNTER - 1
DRAIN_CYCLES, 4, idle cycles between last matrix push and first result pop (PE pipeline latency), >=1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  command strobe; sampled only in IDLE
size  in  NBITS_FOR_COUNTER  dimension N for the command; latched on accepted start
in_valid  in  1  upstream element valid
in_ready  out  1  sequencer can accept an element
push_vec  out  1  vector element write strobe, index col_idx
push_mat  out  1  matrix element write strobe, at row_idx/col_idx
pop_res  out  1  result read strobe for row row_idx
row_idx  out  NBITS_FOR_COUNTER  current row index
col_idx  out  NBITS_FOR_COUNTER  current column index
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on command completion

Behaviour:
- States: IDLE, LOAD_VEC, LOAD_MAT, DRAIN, POP, DONE. Encoding is free.
- reset=1 at a clock edge: state=IDLE, latched N=0, row/col/drain counters=0. All outputs are 0 the following cycle. This holds mid-operation too; partial loads are abandoned with no further strobes.
- IDLE, start=1, size>=1: latch N=size, go to LOAD_VEC.
- IDLE, start=1, size=0: go directly to DONE. No strobes are issued.
- start outside IDLE: ignored. Not queued.
- Transfer = in_valid & in_ready. in_ready=1 exactly in LOAD_VEC and LOAD_MAT.
- push_vec/push_mat are combinational: asserted in the same cycle as the transfer, with the current row_idx/col_idx. No strobe without a transfer. in_valid=0 stalls indefinitely and holds the counters.
- LOAD_VEC: each transfer pulses push_vec and increments col_idx. On the transfer with col_idx=N-1: col_idx←0, row_idx←0, go to LOAD_MAT.
- LOAD_MAT: each transfer pulses push_mat. col_idx increments. On col_idx=N-1: col_idx wraps to 0 and row_idx increments. On the transfer at (N-1,N-1): counters←0, drain counter←0, go to DRAIN.
- DRAIN: exactly DRAIN_CYCLES cycles with no strobes, then go to POP.
- POP: pop_res=1 every cycle for N consecutive cycles, with row_idx=0..N-1. There is no backpressure. After row_idx=N-1, go to DONE.
- DONE: done=1 for one cycle, busy=1, then go to IDLE. A start in the cycle after DONE is accepted normally.
- Index arithmetic is unsigned NBITS_FOR_COUNTER wide. Compares are against latched N-1, so no overflow occurs at maximum N.
- row_idx/col_idx hold their value in IDLE, DRAIN and DONE. They read 0 after reset and after each state exit described above.
- Total cycles from accepted start to done, with no stalls: N + N*N + DRAIN_CYCLES + N + 1.

Test Plan:
- Basic, N=2, DRAIN_CYCLES=4, in_valid held 1 -> 2 push_vec (col 0,1); 4 push_mat in order (0,0),(0,1),(1,0),(1,1); 4 idle cycles; pop_res rows 0,1; done on cycle 13 after start; busy low after.
- Stall: N=3, in_valid toggled 1,0,1,0... -> exactly 3 push_vec and 9 push_mat. Indices are unchanged across in_valid=0 cycles. No strobe while in_valid=0.
- Max size, NBITS_FOR_COUNTER=3, size=7 -> 49 push_mat, final push at (6,6), 7 pops rows 0..6, no index wrap to 0 before the final element.
- size=0 start -> done pulse 1 cycle after start. Zero push/pop strobes. in_ready stays 0.
- start pulsed during LOAD_MAT with size=5 while running N=2 -> ignored. The run completes as N=2, followed by a single done.
- reset=1 asserted mid-LOAD_MAT at (1,0) -> next cycle busy=0, in_ready=0, indices 0, no done. A new start with size=1 then completes normally: 1 push_vec, 1 push_mat, 1 pop, done.

Source files
------------

// File: rtl/mxv_push_sequencer.sv
// Control sequencer for the MxV datapath: streams the vector, then the matrix
// row-major, into the push counters/PEs, waits out the PE pipeline, then pops
// one result per row and pulses done.
module mxv_push_sequencer #(
   parameter int unsigned NBITS_FOR_COUNTER = 3,
   parameter int unsigned DRAIN_CYCLES      = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [NBITS_FOR_COUNTER-1:0] size,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic                         push_vec,
   output logic                         push_mat,
   output logic                         pop_res,
   output logic [NBITS_FOR_COUNTER-1:0] row_idx,
   output logic [NBITS_FOR_COUNTER-1:0] col_idx,
   output logic                         busy,
   output logic                         done
);

   localparam int unsigned NB = NBITS_FOR_COUNTER;
   localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_VEC,
      S_LOAD_MAT,
      S_DRAIN,
      S_POP,
      S_DONE
   } state_t;

   state_t          r_state;
   state_t          w_next_state;
   logic [NB-1:0]   r_n;
   logic [NB-1:0]   w_next_n;
   logic [NB-1:0]   r_row;
   logic [NB-1:0]   w_next_row;
   logic [NB-1:0]   r_col;
   logic [NB-1:0]   w_next_col;
   logic [DW-1:0]   r_drain;
   logic [DW-1:0]   w_next_drain;
   logic [NB-1:0]   w_last;
   logic            w_xfer;

   // Last valid index for the latched dimension; N>=1 whenever it is used.
   assign w_last = r_n - NB'(1);
   assign w_xfer = in_valid & in_ready;

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_n     <= '0;
         r_row   <= '0;
         r_col   <= '0;
         r_drain <= '0;
      end else begin
         r_state <= w_next_state;
         r_n     <= w_next_n;
         r_row   <= w_next_row;
         r_col   <= w_next_col;
         r_drain <= w_next_drain;
      end
   end

   // Next-state and counter update logic.
   always_comb begin
      w_next_state = r_state;
      w_next_n     = r_n;
      w_next_row   = r_row;
      w_next_col   = r_col;
      w_next_drain = r_drain;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (size != '0) begin
                  w_next_n     = size;
                  w_next_row   = '0;
                  w_next_col   = '0;
                  w_next_state = S_LOAD_VEC;
               end else begin
                  w_next_state = S_DONE;
               end
            end
         end
         S_LOAD_VEC: begin
            if (w_xfer) begin
               if (r_col == w_last) begin
                  w_next_col   = '0;
                  w_next_row   = '0;
                  w_next_state = S_LOAD_MAT;
               end else begin
                  w_next_col = r_col + NB'(1);
               end
            end
         end
         S_LOAD_MAT: begin
            if (w_xfer) begin
               if (r_col == w_last) begin
                  w_next_col = '0;
                  if (r_row == w_last) begin
                     w_next_row   = '0;
                     w_next_drain = '0;
                     w_next_state = S_DRAIN;
                  end else begin
                     w_next_row = r_row + NB'(1);
                  end
               end else begin
                  w_next_col = r_col + NB'(1);
               end
            end
         end
         S_DRAIN: begin
            if (r_drain == DW'(DRAIN_CYCLES - 1)) begin
               w_next_drain = '0;
               w_next_state = S_POP;
            end else begin
               w_next_drain = r_drain + DW'(1);
            end
         end
         S_POP: begin
            if (r_row == w_last) begin
               w_next_row   = '0;
               w_next_state = S_DONE;
            end else begin
               w_next_row = r_row + NB'(1);
            end
         end
         S_DONE: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Outputs decoded from the state register; push strobes follow the transfer.
   assign in_ready = (r_state == S_LOAD_VEC) || (r_state == S_LOAD_MAT);
   assign push_vec = in_valid && (r_state == S_LOAD_VEC);
   assign push_mat = in_valid && (r_state == S_LOAD_MAT);
   assign pop_res  = (r_state == S_POP);
   assign busy     = (r_state != S_IDLE);
   assign done     = (r_state == S_DONE);
   assign row_idx  = r_row;
   assign col_idx  = r_col;

endmodule
